// File: rtl/reg_file_sequencer.sv
// reg_file_sequencer: the initiator side of the register-file port in the 8-bit core.
// It takes one ALU command, reads both operands through the register file's
// one-cycle registered read port, hands them to the ALU and then writes the result back.
// Optional build macro RF_WRITE_VERIFY_EN: reads back the destination after the
// write-back and flags ERR if the stored value differs from the result.
module reg_file_sequencer #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 4,
  parameter int NREGS   = 4,
  parameter int TMO_CYC = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic [ADDR_W-1:0] i_cmd_src_a,
  input  logic [ADDR_W-1:0] i_cmd_src_b,
  input  logic [ADDR_W-1:0] i_cmd_dst,
  input  logic              i_cmd_wb,
  output logic              o_op_valid,
  output logic [DATA_W-1:0] o_op_a,
  output logic [DATA_W-1:0] o_op_b,
  input  logic              i_res_valid,
  input  logic [DATA_W-1:0] i_res_data,
  output logic [ADDR_W-1:0] o_rf_addr,
  output logic              o_rf_ce,
  output logic [DATA_W-1:0] o_rf_wdata,
  input  logic [DATA_W-1:0] i_rf_rdata,
  output logic              o_done,
  output logic              o_err
);

  localparam int CNT_W = (TMO_CYC > 2) ? $clog2(TMO_CYC) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TMO_CYC - 1);
  localparam logic [ADDR_W:0]   NREGS_L  = (ADDR_W + 1)'(NREGS);

  typedef enum logic [3:0] {
    S_IDLE,
    S_RD_A,
    S_RD_B,
    S_CAP_B,
    S_EXEC,
    S_WR,
`ifdef RF_WRITE_VERIFY_EN
    S_VFY_A,
    S_VFY_C,
`endif
    S_RET
  } state_t;

  state_t             r_state;
  logic               r_cmd_ready;
  logic               r_op_valid;
  logic [DATA_W-1:0]  r_op_a;
  logic [DATA_W-1:0]  r_op_b;
  logic [ADDR_W-1:0]  r_rf_addr;
  logic               r_rf_ce;
  logic [DATA_W-1:0]  r_rf_wdata;
  logic               r_done;
  logic               r_err;
  logic               r_bad_addr;
  logic [ADDR_W-1:0]  r_src_b;
  logic [ADDR_W-1:0]  r_dst;
  logic               r_wb;
  logic [CNT_W-1:0]   r_cnt;
  logic               w_handshake;
  logic               w_illegal;

  assign w_handshake = i_cmd_valid && r_cmd_ready;

  // Any latched address beyond the implemented registers rejects the whole command.
  assign w_illegal = ({1'b0, i_cmd_src_a} >= NREGS_L) ||
                     ({1'b0, i_cmd_src_b} >= NREGS_L) ||
                     ({1'b0, i_cmd_dst}   >= NREGS_L);

  // Sequencer FSM. Every output is registered and is loaded on the transition
  // into the state that owns it, so each output is a clean Moore decode of r_state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_cmd_ready <= 1'b1;
      r_op_valid  <= 1'b0;
      r_op_a      <= '0;
      r_op_b      <= '0;
      r_rf_addr   <= '0;
      r_rf_ce     <= 1'b0;
      r_rf_wdata  <= '0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_bad_addr  <= 1'b0;
      r_src_b     <= '0;
      r_dst       <= '0;
      r_wb        <= 1'b0;
      r_cnt       <= '0;
    end else begin
      // Pulses default low; they are raised only on the single transition that owns them.
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_rf_ce <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_handshake) begin
            r_cmd_ready <= 1'b0;
            r_src_b     <= i_cmd_src_b;
            r_dst       <= i_cmd_dst;
            r_wb        <= i_cmd_wb;
            r_bad_addr  <= w_illegal;
            r_state     <= S_RD_A;
            // A rejected command never touches the register-file address.
            if (!w_illegal) begin
              r_rf_addr <= i_cmd_src_a;
            end
          end
        end
        S_RD_A: begin
          // This cycle doubles as the address check; a rejected command retires from here.
          if (r_bad_addr) begin
            r_state <= S_RET;
            r_done  <= 1'b1;
            r_err   <= 1'b1;
          end else begin
            r_rf_addr <= r_src_b;
            r_state   <= S_RD_B;
          end
        end
        S_RD_B: begin
          // Read data for SRC_A arrives one cycle after its address.
          r_op_a  <= i_rf_rdata;
          r_state <= S_CAP_B;
        end
        S_CAP_B: begin
          r_op_b     <= i_rf_rdata;
          r_op_valid <= 1'b1;
          r_cnt      <= '0;
          r_state    <= S_EXEC;
        end
        S_EXEC: begin
          if (i_res_valid) begin
            r_op_valid <= 1'b0;
            if (r_wb) begin
              r_rf_addr  <= r_dst;
              r_rf_ce    <= 1'b1;
              r_rf_wdata <= i_res_data;
              r_state    <= S_WR;
            end else begin
              r_done  <= 1'b1;
              r_state <= S_RET;
            end
          end else if (r_cnt == CNT_LAST) begin
            // The ALU went silent for the full window: abort without writing.
            r_op_valid <= 1'b0;
            r_done     <= 1'b1;
            r_err      <= 1'b1;
            r_state    <= S_RET;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_WR: begin
`ifdef RF_WRITE_VERIFY_EN
          // RF_ADDR stays on DST so the next two cycles read the written location back.
          r_state <= S_VFY_A;
`else
          r_done  <= 1'b1;
          r_state <= S_RET;
`endif
        end
`ifdef RF_WRITE_VERIFY_EN
        S_VFY_A: begin
          r_state <= S_VFY_C;
        end
        S_VFY_C: begin
          // Data now reflects the post-write contents of DST; r_rf_wdata still holds the result.
          r_done  <= 1'b1;
          r_err   <= (i_rf_rdata != r_rf_wdata);
          r_state <= S_RET;
        end
`endif
        S_RET: begin
          r_cmd_ready <= 1'b1;
          r_state     <= S_IDLE;
        end
        default: begin
          r_cmd_ready <= 1'b1;
          r_op_valid  <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign o_cmd_ready = r_cmd_ready;
  assign o_op_valid  = r_op_valid;
  assign o_op_a      = r_op_a;
  assign o_op_b      = r_op_b;
  assign o_rf_addr   = r_rf_addr;
  assign o_rf_ce     = r_rf_ce;
  assign o_rf_wdata  = r_rf_wdata;
  assign o_done      = r_done;
  assign o_err       = r_err;

endmodule

// File: tb/tb_reg_file_sequencer.sv
// Directed bench for reg_file_sequencer: a behavioural register file with a
// one-cycle registered read, plus a simple ALU responder driven from the stimulus.
module tb_reg_file_sequencer;

`ifdef RF_WRITE_VERIFY_EN
  localparam int LAT_WB = 8;
`else
  localparam int LAT_WB = 6;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [3:0] src_a = '0, src_b = '0, dst = '0;
  logic       wb = 1'b0;
  logic       op_valid;
  logic [7:0] op_a, op_b;
  logic       res_valid = 1'b0;
  logic [7:0] res_data = '0;
  logic [3:0] rf_addr;
  logic       rf_ce;
  logic [7:0] rf_wdata;
  logic [7:0] rf_rdata;
  logic       done, err;

  logic       rf_init = 1'b1;
  logic       corrupt = 1'b0;
  logic [7:0] mem [16];

  int n_cmp = 0;
  int n_bad = 0;

  // per-command observations
  int         done_n, ce_cnt, ready_hi;
  logic       done_err, opv_seen, addr_moved;
  logic [3:0] ce_addr;
  logic [7:0] ce_data, seen_a, seen_b;

  always #5 clk = ~clk;

  reg_file_sequencer dut (
    .i_clk(clk), .i_rst(rst),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
    .i_cmd_src_a(src_a), .i_cmd_src_b(src_b), .i_cmd_dst(dst), .i_cmd_wb(wb),
    .o_op_valid(op_valid), .o_op_a(op_a), .o_op_b(op_b),
    .i_res_valid(res_valid), .i_res_data(res_data),
    .o_rf_addr(rf_addr), .o_rf_ce(rf_ce), .o_rf_wdata(rf_wdata), .i_rf_rdata(rf_rdata),
    .o_done(done), .o_err(err)
  );

  // Register file model: registered read, write on CE; optional corrupted write.
  always @(posedge clk) begin
    if (rf_init) begin
      for (int i = 0; i < 16; i++) mem[i] <= (i < 4) ? 8'(i + 2) : 8'h00;
      rf_rdata <= 8'h00;
    end else begin
      rf_rdata <= mem[rf_addr];
      if (rf_ce) mem[rf_addr] <= corrupt ? 8'hFF : rf_wdata;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Offer one command, then watch it on negedges until DONE or a 60-cycle bound.
  task automatic run_cmd(input logic [3:0] a, input logic [3:0] b, input logic [3:0] d,
                         input logic w, input logic alu_en, input logic [7:0] res);
    logic [3:0] addr0;
    @(negedge clk);
    addr0 = rf_addr;
    src_a = a; src_b = b; dst = d; wb = w; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    done_n = 0; done_err = 1'b0; ce_cnt = 0; ready_hi = 0;
    opv_seen = 1'b0; addr_moved = 1'b0; ce_addr = '0; ce_data = '0; seen_a = '0; seen_b = '0;
    for (int n = 1; n <= 60; n++) begin
      if (rf_addr != addr0) addr_moved = 1'b1;
      if (cmd_ready) ready_hi++;
      if (rf_ce) begin ce_cnt++; ce_addr = rf_addr; ce_data = rf_wdata; end
      if (op_valid) begin opv_seen = 1'b1; seen_a = op_a; seen_b = op_b; end
      res_valid = alu_en && op_valid;
      res_data  = res;
      if (done) begin done_n = n; done_err = err; break; end
      @(negedge clk);
    end
    res_valid = 1'b0;
    $display("cmd A=%0d B=%0d D=%0d WB=%0d: done@%0d err=%0b opA=%0h opB=%0h writes=%0d",
             a, b, d, w, done_n, done_err, seen_a, seen_b, ce_cnt);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rf_init = 1'b0;
    rst = 1'b0;
    // reset values
    check("rst_ready", 32'(cmd_ready), 1);
    check("rst_opvalid", 32'(op_valid), 0);
    check("rst_op_ab", {op_a, op_b}, 0);
    check("rst_rf", {rf_addr, rf_ce, rf_wdata}, 0);
    check("rst_done_err", {done, err}, 0);

    // 1: legal write-back, ALU answers in first EXEC cycle
    run_cmd(4'd1, 4'd3, 4'd0, 1'b1, 1'b1, 8'd8);
    check("t1_op_a", seen_a, 3);
    check("t1_op_b", seen_b, 5);
    check("t1_writes", ce_cnt, 1);
    check("t1_wr_addr", ce_addr, 0);
    check("t1_wr_data", ce_data, 8);
    check("t1_latency", done_n, LAT_WB);
    check("t1_err", done_err, 0);
    check("t1_ready_low", ready_hi, 0);
    check("t1_mem0", mem[0], 8);

    // 2: same source twice, no write-back
    run_cmd(4'd2, 4'd2, 4'd2, 1'b0, 1'b1, 8'd9);
    check("t2_op_a", seen_a, 4);
    check("t2_op_b", seen_b, 4);
    check("t2_writes", ce_cnt, 0);
    check("t2_latency", done_n, 5);
    check("t2_err", done_err, 0);
    check("t2_mem2", mem[2], 4);

    // 3: illegal source address
    run_cmd(4'd5, 4'd0, 4'd1, 1'b1, 1'b1, 8'd1);
    check("t3_latency", done_n, 2);
    check("t3_err", done_err, 1);
    check("t3_opvalid", opv_seen, 0);
    check("t3_addr_moved", addr_moved, 0);
    check("t3_writes", ce_cnt, 0);

    // 4: ALU never answers -> timeout after 16 EXEC cycles
    run_cmd(4'd0, 4'd1, 4'd3, 1'b1, 1'b0, 8'd0);
    check("t4_latency", done_n, 20);
    check("t4_err", done_err, 1);
    check("t4_writes", ce_cnt, 0);
    check("t4_mem3", mem[3], 5);

    // 5: reset while in EXEC, then a normal command
    @(negedge clk);
    src_a = 4'd1; src_b = 4'd2; dst = 4'd3; wb = 1'b1; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int n = 0; n < 10 && !op_valid; n++) @(negedge clk);
    check("t5_in_exec", 32'(op_valid), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t5_ready", 32'(cmd_ready), 1);
    check("t5_opvalid", 32'(op_valid), 0);
    check("t5_done", {done, rf_ce}, 0);
    $display("reset in EXEC: ready=%0b op_valid=%0b done=%0b", cmd_ready, op_valid, done);
    run_cmd(4'd3, 4'd1, 4'd1, 1'b1, 1'b1, 8'h21);
    check("t5b_op_a", seen_a, 5);
    check("t5b_op_b", seen_b, 3);
    check("t5b_latency", done_n, LAT_WB);
    check("t5b_err", done_err, 0);
    check("t5b_mem1", mem[1], 8'h21);
    check("t5_mem3", mem[3], 5);

`ifdef RF_WRITE_VERIFY_EN
    // 6: register file stores a corrupted value -> verify flags ERR
    corrupt = 1'b1;
    run_cmd(4'd0, 4'd0, 4'd2, 1'b1, 1'b1, 8'd7);
    corrupt = 1'b0;
    check("t6_latency", done_n, 8);
    check("t6_err", done_err, 1);
    check("t6_mem2", mem[2], 8'hFF);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
